// File: rtl/glycemic_sample_ctrl_pkg.sv
// Shared types and widths for the glycemic sampling sequencer.
package glycemic_pkg;

    localparam int unsigned GI_W     = 4;
    localparam int unsigned SENSOR_W = 8;

    localparam logic [GI_W-1:0] GI_HIGH_DEF = 4'd10;
    localparam logic [GI_W-1:0] GI_LOW_DEF  = 4'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        CALC      = 3'd3,
        ACC       = 3'd4,
        REPORT    = 3'd5
    } gs_state_e;

endpackage

// File: rtl/glycemic_sample_ctrl_if.sv
// Blood-sensor request/response bus between the sequencer and the sensor.
interface glycemic_sample_ctrl_if;
    import glycemic_pkg::*;

    logic                sensor_req;
    logic                sensor_valid;
    logic [SENSOR_W-1:0] sensor_data;

    // Sequencer side: raises requests, consumes readings
    modport master (
        output sensor_req,
        input  sensor_valid,
        input  sensor_data
    );

    // Sensor side: answers requests with a reading
    modport slave (
        input  sensor_req,
        output sensor_valid,
        output sensor_data
    );

endinterface

// File: rtl/glycemic_sample_ctrl_alarm.sv
// Run-length alarm tracker: counts consecutive high/low window reports.
module gi_alarm_tracker
    import glycemic_pkg::*;
#(
    parameter logic [GI_W-1:0] GI_HIGH   = GI_HIGH_DEF,
    parameter logic [GI_W-1:0] GI_LOW    = GI_LOW_DEF,
    parameter int unsigned     ALARM_RUN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_update,
    input  logic [GI_W-1:0] i_avg,
    output logic            o_alarm_hi,
    output logic            o_alarm_lo
);

    localparam int unsigned      RUN_W   = $clog2(ALARM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALARM_RUN);

    logic [RUN_W-1:0] r_hi_run;
    logic [RUN_W-1:0] r_lo_run;
    logic [RUN_W-1:0] w_hi_run_nxt;
    logic [RUN_W-1:0] w_lo_run_nxt;
    logic             r_alarm_hi;
    logic             r_alarm_lo;

    // Saturating run counters, advanced only on a window report
    always_comb begin
        w_hi_run_nxt = r_hi_run;
        w_lo_run_nxt = r_lo_run;
        if (i_update) begin
            if (i_avg >= GI_HIGH)
                w_hi_run_nxt = (r_hi_run == RUN_MAX) ? RUN_MAX : r_hi_run + RUN_W'(1);
            else
                w_hi_run_nxt = '0;
            if (i_avg <= GI_LOW)
                w_lo_run_nxt = (r_lo_run == RUN_MAX) ? RUN_MAX : r_lo_run + RUN_W'(1);
            else
                w_lo_run_nxt = '0;
        end
    end

    // Run counters and alarm flags change on the same edge as the report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_run   <= '0;
            r_lo_run   <= '0;
            r_alarm_hi <= 1'b0;
            r_alarm_lo <= 1'b0;
        end else begin
            r_hi_run   <= w_hi_run_nxt;
            r_lo_run   <= w_lo_run_nxt;
            r_alarm_hi <= (w_hi_run_nxt >= RUN_MAX);
            r_alarm_lo <= (w_lo_run_nxt >= RUN_MAX);
        end
    end

    assign o_alarm_hi = r_alarm_hi;
    assign o_alarm_lo = r_alarm_lo;

endmodule

// File: rtl/glycemic_sample_ctrl.sv
// Periodic blood-sensor sampler feeding the GI calculator, with windowed average and alarms.
module glycemic_sample_ctrl
    import glycemic_pkg::*;
#(
    parameter int unsigned     SAMPLE_PERIOD = 16,
    parameter int unsigned     AVG_LOG2      = 2,
    parameter logic [GI_W-1:0] GI_HIGH       = GI_HIGH_DEF,
    parameter logic [GI_W-1:0] GI_LOW        = GI_LOW_DEF,
    parameter int unsigned     ALARM_RUN     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    glycemic_sample_ctrl_if.master  sens,
    output logic [SENSOR_W-1:0]     calc_in,
    input  logic [GI_W-1:0]         calc_out,
    output logic [GI_W-1:0]         gi_avg,
    output logic                    gi_valid,
    output logic                    alarm_hi,
    output logic                    alarm_lo,
    output logic                    overrun
);

    localparam int unsigned       TICK_W    = $clog2(SAMPLE_PERIOD);
    localparam int unsigned       ACC_W     = GI_W + AVG_LOG2;
    localparam int unsigned       CNT_W     = AVG_LOG2 + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(1 << AVG_LOG2);

    gs_state_e           r_state;
    gs_state_e           w_state_nxt;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SENSOR_W-1:0] r_calc_in;
    logic [SENSOR_W-1:0] w_calc_in_nxt;
    logic [GI_W-1:0]     r_gi_avg;
    logic [GI_W-1:0]     w_gi_avg_nxt;
    logic                r_gi_valid;
    logic                r_sensor_req;
    logic                r_overrun;
    logic                w_overrun_nxt;
    logic                w_report;

    logic                w_tick;
    logic                w_accept;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_win_done;

    assign w_tick     = enable && (r_state != IDLE) && (r_tick == TICK_LAST);
    assign w_accept   = r_sensor_req && sens.sensor_valid;
    assign w_acc_sum  = r_acc + ACC_W'(calc_out);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_win_done = (w_cnt_inc == CNT_FULL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; enable low overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:      w_state_nxt = WAIT_TICK;
                WAIT_TICK: if (w_tick) w_state_nxt = REQ;
                REQ:       if (w_accept) w_state_nxt = CALC;
                CALC:      w_state_nxt = ACC;
                ACC:       w_state_nxt = w_win_done ? REPORT : WAIT_TICK;
                REPORT:    w_state_nxt = WAIT_TICK;
                default:   w_state_nxt = IDLE;
            endcase
        end
    end

    // Next values of datapath and outputs; the report is committed on the edge into REPORT
    always_comb begin
        w_tick_nxt    = r_tick;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_calc_in_nxt = r_calc_in;
        w_gi_avg_nxt  = r_gi_avg;
        w_overrun_nxt = r_overrun;
        w_report      = 1'b0;
        if (!enable) begin
            w_tick_nxt    = '0;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_overrun_nxt = 1'b0;
        end else begin
            if (r_state == IDLE || r_tick == TICK_LAST) w_tick_nxt = '0;
            else                                        w_tick_nxt = r_tick + TICK_W'(1);
            if (w_tick && r_state != WAIT_TICK) w_overrun_nxt = 1'b1;
            if (r_state == REQ && w_accept) w_calc_in_nxt = sens.sensor_data;
            if (r_state == ACC) begin
                if (w_win_done) begin
                    w_gi_avg_nxt = GI_W'(w_acc_sum >> AVG_LOG2);
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_report     = 1'b1;
                end else begin
                    w_acc_nxt = w_acc_sum;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick       <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_calc_in    <= '0;
            r_gi_avg     <= '0;
            r_gi_valid   <= 1'b0;
            r_sensor_req <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tick       <= w_tick_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_calc_in    <= w_calc_in_nxt;
            r_gi_avg     <= w_gi_avg_nxt;
            r_gi_valid   <= (w_state_nxt == REPORT);
            r_sensor_req <= (w_state_nxt == REQ);
            r_overrun    <= w_overrun_nxt;
        end
    end

    gi_alarm_tracker #(
        .GI_HIGH   (GI_HIGH),
        .GI_LOW    (GI_LOW),
        .ALARM_RUN (ALARM_RUN)
    ) u_alarm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_update   (w_report),
        .i_avg      (w_gi_avg_nxt),
        .o_alarm_hi (alarm_hi),
        .o_alarm_lo (alarm_lo)
    );

    assign sens.sensor_req = r_sensor_req;
    assign calc_in         = r_calc_in;
    assign gi_avg          = r_gi_avg;
    assign gi_valid        = r_gi_valid;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_glycemic_sample_ctrl.sv
// Bench for glycemic_sample_ctrl: window table plus hand-written corner sequences.
module tb_glycemic_sample_ctrl;
    import glycemic_pkg::*;

    localparam int unsigned P = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] calc_in;
    logic [3:0] calc_out;
    logic [3:0] gi_avg;
    logic       gi_valid;
    logic       alarm_hi;
    logic       alarm_lo;
    logic       overrun;

    glycemic_sample_ctrl_if sens ();

    // Stub calculator
    assign calc_out = calc_in[7:4];

    glycemic_sample_ctrl #(
        .SAMPLE_PERIOD (P),
        .AVG_LOG2      (2),
        .GI_HIGH       (4'd10),
        .GI_LOW        (4'd3),
        .ALARM_RUN     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sens     (sens),
        .calc_in  (calc_in),
        .calc_out (calc_out),
        .gi_avg   (gi_avg),
        .gi_valid (gi_valid),
        .alarm_hi (alarm_hi),
        .alarm_lo (alarm_lo),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  avg;
        logic        hi;
        logic        lo;
        logic [31:0] acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    typedef struct packed {
        logic [3:0][7:0] s;
        logic [7:0]      dly;
        logic [3:0]      avg;
        logic            hi;
        logic            lo;
        logic            hold;
    } win_t;

    win_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic win_t mk(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] dly, input logic [3:0] avg,
                                input logic hi, input logic lo, input logic hold);
        win_t w;
        w.s[0] = b0; w.s[1] = b1; w.s[2] = b2; w.s[3] = b3;
        w.dly  = dly;
        w.avg  = avg;
        w.hi   = hi;
        w.lo   = lo;
        w.hold = hold;
        return w;
    endfunction

    // Report monitor: pops the scoreboard on every gi_valid pulse
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && gi_valid === 1'b1) begin
            check("gi_valid_one_cycle", 32'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL report_unexpected actual=gi_avg %0d required=no report (t=%0t)", gi_avg, $time);
            end else begin
                e = exp_q.pop_front();
                check("gi_avg", 32'(gi_avg), 32'(e.avg));
                check("alarm_hi", 32'(alarm_hi), 32'(e.hi));
                check("alarm_lo", 32'(alarm_lo), 32'(e.lo));
                // accept edge starts CALC; REPORT is the third cycle after the accept
                check("report_latency", cyc - int'(e.acc_cyc), 2);
            end
        end
        prev_valid = (rst_n === 1'b1) ? gi_valid : 1'b0;
    end

    // Sensor model: answer the pending request after dly cycles; call at a negedge
    task automatic do_sample(input logic [7:0] d, input int dly, output int acc_cyc);
        int n = 0;
        acc_cyc = 0;
        while (sens.sensor_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sens.sensor_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL sensor_req_timeout actual=0 required=1 (t=%0t)", $time);
            return;
        end
        repeat (dly) @(negedge clk);
        sens.sensor_valid = 1'b1;
        sens.sensor_data  = d;
        @(negedge clk);
        sens.sensor_valid = 1'b0;
        sens.sensor_data  = 8'hEE;
        acc_cyc = cyc;
        check("calc_in", 32'(calc_in), 32'(d));
    endtask

    task automatic push_exp(input logic [3:0] avg, input logic hi, input logic lo, input int acc_cyc);
        exp_t e;
        e.avg     = avg;
        e.hi      = hi;
        e.lo      = lo;
        e.acc_cyc = 32'(acc_cyc);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sensor_req"}, 32'(sens.sensor_req), 0);
        check({tag, "_calc_in"},    32'(calc_in), 0);
        check({tag, "_gi_avg"},     32'(gi_avg), 0);
        check({tag, "_gi_valid"},   32'(gi_valid), 0);
        check({tag, "_alarm_hi"},   32'(alarm_hi), 0);
        check({tag, "_alarm_lo"},   32'(alarm_lo), 0);
        check({tag, "_overrun"},    32'(overrun), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ac;
        tbl[0]  = mk(8'hAA, 8'h12, 8'h9F, 8'h71, 8'd0, 4'd6,  1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'd1, 4'd11, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'd0, 4'd11, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(8'h50, 8'h50, 8'h50, 8'h50, 8'd2, 4'd5,  1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(8'h20, 8'h20, 8'h20, 8'h20, 8'd0, 4'd2,  1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(8'h20, 8'h20, 8'h20, 8'h20, 8'd0, 4'd2,  1'b0, 1'b1, 1'b1);
        tbl[6]  = mk(8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'd3, 4'd10, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'd0, 4'd10, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(8'h30, 8'h30, 8'h30, 8'h30, 8'd1, 4'd3,  1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(8'h3F, 8'h3F, 8'h3F, 8'h4F, 8'd0, 4'd3,  1'b0, 1'b1, 1'b0);
        tbl[10] = mk(8'h9F, 8'h9F, 8'hAF, 8'h9F, 8'd0, 4'd9,  1'b0, 1'b0, 1'b0);
        tbl[11] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 4'd15, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd1, 4'd15, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 4'd15, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd2, 4'd15, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(8'h50, 8'h50, 8'h50, 8'h50, 8'd0, 4'd5,  1'b0, 1'b0, 1'b0);

        rst_n             = 1'b1;
        enable            = 1'b0;
        sens.sensor_valid = 1'b0;
        sens.sensor_data  = 8'hEE;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Window table
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                do_sample(tbl[i].s[k], int'(tbl[i].dly), ac);
                if (k == 3) push_exp(tbl[i].avg, tbl[i].hi, tbl[i].lo, ac);
            end
            if (tbl[i].hold) begin
                wait_drain("drain_before_hold");
                enable            = 1'b0;
                sens.sensor_valid = 1'b1;
                repeat (4) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    check("hold_gi_avg",     32'(gi_avg), 32'(tbl[i].avg));
                    check("hold_alarm_lo",   32'(alarm_lo), 32'(tbl[i].lo));
                    check("hold_alarm_hi",   32'(alarm_hi), 32'(tbl[i].hi));
                    check("hold_sensor_req", 32'(sens.sensor_req), 0);
                    repeat (8) @(negedge clk);
                end
                sens.sensor_valid = 1'b0;
                enable            = 1'b1;
            end
        end
        wait_drain("drain_table");
        check("no_overrun_in_table", 32'(overrun), 0);

        // Overrun: stall the sensor for two tick periods
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        do_sample(8'h60, 2 * P, ac);
        check("overrun_set", 32'(overrun), 1);
        for (int k = 0; k < 3; k++) do_sample(8'h60, 0, ac);
        push_exp(4'd6, 1'b0, 1'b0, ac);
        wait_drain("drain_overrun");
        check("overrun_sticky", 32'(overrun), 1);
        enable = 1'b0;
        @(negedge clk);
        check("overrun_cleared_by_enable", 32'(overrun), 0);
        enable = 1'b1;

        // Enable drop mid-window: partial window must be discarded
        do_sample(8'hF0, 0, ac);
        do_sample(8'hF0, 0, ac);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) do_sample(8'h40, 0, ac);
        push_exp(4'd4, 1'b0, 1'b0, ac);
        wait_drain("drain_enable_drop");

        // Asynchronous reset while waiting in REQ with overrun raised
        begin
            int n = 0;
            while (sens.sensor_req !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (P + 2) @(negedge clk);
        check("pre_reset_sensor_req", 32'(sens.sensor_req), 1);
        check("pre_reset_overrun", 32'(overrun), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) do_sample(8'h12, 0, ac);
        push_exp(4'd1, 1'b0, 1'b0, ac);
        wait_drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
